mac_scheduler: RTL



---
 rtl/mac_scheduler_if.sv | 37 +++
 rtl/mac_scheduler.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mac_scheduler_if.sv
// Purpose : bundles the scheduler's control, weight-SRAM, MAC and result signals.
// Latency : none; this is a pure wiring bundle.
// Backpr. : none; all transfers are strobes (start, wmem_rd_en, mac_valid, acc_valid, done).
// master : the scheduler (drives busy/done, wmem_rd_en/addr, mac_*, acc_*).
// slave  : the environment (drives start/spikes, wmem_rdata, mac_result).
interface mac_scheduler_if #(
  parameter int NUM_GROUPS = 4,
  parameter int WADDR_W    = 4,
  parameter int NIDX_W     = 2
);
  logic                    start;
  logic [4*NUM_GROUPS-1:0] spikes;
  logic                    busy;
  logic                    done;
  logic                    wmem_rd_en;
  logic [WADDR_W-1:0]      wmem_addr;
  logic [127:0]            wmem_rdata;
  logic [3:0]              mac_spike;
  logic [127:0]            mac_weights;
  logic                    mac_valid;
  logic [31:0]             mac_result;
  logic                    acc_valid;
  logic [NIDX_W-1:0]       acc_neuron;
  logic [31:0]             acc_out;

  modport master (
    input  start, spikes, wmem_rdata, mac_result,
    output busy, done, wmem_rd_en, wmem_addr, mac_spike, mac_weights,
           mac_valid, acc_valid, acc_neuron, acc_out
  );

  modport slave (
    output start, spikes, wmem_rdata, mac_result,
    input  busy, done, wmem_rd_en, wmem_addr, mac_spike, mac_weights,
           mac_valid, acc_valid, acc_neuron, acc_out
  );
endinterface

// File: rtl/mac_scheduler.sv
// Purpose : shares one spike-gated 4-lane MAC across NUM_NEURONS neurons for one SNN timestep.
// Latency : nonzero group 3+MAC_LATENCY cycles, zero group 1 cycle, +1 EMIT cycle per neuron.
// Backpr. : none; start is accepted only in IDLE and ignored otherwise.
// Ports   : CLK, RESET (sync, active-high); bus = mac_scheduler_if.master
//           (start/spikes in, busy/done out, weight SRAM read port, MAC port, acc result port).
module mac_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_GROUPS  = 4,
  parameter int MAC_LATENCY = 1,
  parameter int WADDR_W     = 4,
  parameter int NIDX_W      = 2
) (
  input logic              CLK,
  input logic              RESET,
  mac_scheduler_if.master  bus
);
  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int CW = $clog2(MAC_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, RD, ISSUE, WAIT, ACC, EMIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [4*NUM_GROUPS-1:0] spk_q;
  logic [NIDX_W-1:0]       neuron_q;
  logic [GW-1:0]           group_q;
  logic [CW-1:0]           wait_q;
  logic [31:0]             acc_q;

  // Hold registers: these outputs keep their last pulsed value between pulses.
  logic [WADDR_W-1:0]      addr_q;
  logic [3:0]              spike_q;
  logic [127:0]            weights_q;
  logic [31:0]             acc_out_q;
  logic [NIDX_W-1:0]       acc_neuron_q;

  logic [3:0]              nibble;
  logic [WADDR_W-1:0]      addr_c;
  logic                    last_group;
  logic                    last_neuron;
  logic                    rd_fire;

  assign nibble      = spk_q[4*group_q +: 4];
  assign addr_c      = WADDR_W'(neuron_q) * WADDR_W'(NUM_GROUPS) + WADDR_W'(group_q);
  assign last_group  = (group_q == GW'(NUM_GROUPS - 1));
  assign last_neuron = (neuron_q == NIDX_W'(NUM_NEURONS - 1));
  assign rd_fire     = (state_q == RD) && (nibble != 4'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RD;
      // All-zero nibble contributes nothing, so it skips the read and MAC entirely.
      RD:      if (nibble != 4'd0) state_d = ISSUE;
               else                state_d = last_group ? EMIT : RD;
      ISSUE:   state_d = WAIT;
      // Counter holds the remaining wait cycles including the current one.
      WAIT:    if (wait_q == CW'(1)) state_d = ACC;
      ACC:     state_d = last_group ? EMIT : RD;
      EMIT:    state_d = last_neuron ? DONE : RD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pulses are decoded from state; held outputs bypass their register during the pulse cycle.
  always_comb begin
    bus.busy        = (state_q != IDLE) && (state_q != DONE);
    bus.done        = (state_q == DONE);
    bus.wmem_rd_en  = rd_fire;
    bus.wmem_addr   = rd_fire ? addr_c : addr_q;
    bus.mac_valid   = (state_q == ISSUE);
    bus.mac_spike   = (state_q == ISSUE) ? nibble : spike_q;
    bus.mac_weights = (state_q == ISSUE) ? bus.wmem_rdata : weights_q;
    bus.acc_valid   = (state_q == EMIT);
    bus.acc_out     = (state_q == EMIT) ? acc_q : acc_out_q;
    bus.acc_neuron  = (state_q == EMIT) ? neuron_q : acc_neuron_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      spk_q        <= '0;
      neuron_q     <= '0;
      group_q      <= '0;
      wait_q       <= '0;
      acc_q        <= '0;
      addr_q       <= '0;
      spike_q      <= '0;
      weights_q    <= '0;
      acc_out_q    <= '0;
      acc_neuron_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.start) begin
          spk_q    <= bus.spikes;
          neuron_q <= '0;
          group_q  <= '0;
          acc_q    <= '0;
        end
        RD: begin
          if (rd_fire)          addr_q  <= addr_c;
          else if (!last_group) group_q <= group_q + 1'b1;
        end
        ISSUE: begin
          spike_q   <= nibble;
          weights_q <= bus.wmem_rdata;
          wait_q    <= CW'(MAC_LATENCY);
        end
        WAIT: wait_q <= wait_q - 1'b1;
        ACC: begin
          acc_q <= acc_q + bus.mac_result;
          if (!last_group) group_q <= group_q + 1'b1;
        end
        EMIT: begin
          acc_out_q    <= acc_q;
          acc_neuron_q <= neuron_q;
          acc_q        <= '0;
          group_q      <= '0;
          if (!last_neuron) neuron_q <= neuron_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
